// File: rtl/voice_allocator_pkg.sv
// -----------------------------------------------------------------------------
// voice_allocator_pkg
// Shared types and constants for the polyphonic voice allocator.
//   VOICE_COUNT      default number of voices / envelopes driven
//   VOICE_AGE_WIDTH  width of a per-voice age counter at VOICE_COUNT
//   voice_state_t    per-voice lifecycle: FREE -> HELD -> RELEASING -> FREE
//   note_event_t     one decoded MIDI note event
//   sat_inc16        saturating 16-bit increment used by the drop counter
// -----------------------------------------------------------------------------
package voice_allocator_pkg;

    localparam int VOICE_COUNT     = 8;
    localparam int NOTE_W          = 7;
    localparam int VOICE_AGE_WIDTH = $clog2(VOICE_COUNT);

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        HELD      = 2'd1,
        RELEASING = 2'd2
    } voice_state_t;

    typedef struct packed {
        logic              is_on;
        logic [NOTE_W-1:0] note;
        logic [NOTE_W-1:0] velocity;
    } note_event_t;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/voice_picker.sv
// -----------------------------------------------------------------------------
// voice_picker
// Combinational selector over a per-voice candidate mask.
//   MODE 0: index of the lowest-index set bit of mask.
//   MODE 1: index of the candidate with the largest age, ties going to the
//           lowest index.
// Ports:
//   mask   in  VOICES       candidate voices
//   ages   in  VOICES x AW  per-voice age (only consulted in MODE 1)
//   found  out 1            at least one candidate present
//   index  out AW           selected voice (0 when nothing found)
// -----------------------------------------------------------------------------
module voice_picker #(
    parameter int VOICES = 8,
    parameter int AW     = $clog2(VOICES),
    parameter bit MODE   = 1'b0
) (
    input  logic [VOICES-1:0]         mask,
    input  logic [VOICES-1:0][AW-1:0] ages,
    output logic                      found,
    output logic [AW-1:0]             index
);

    logic [AW-1:0] best_age_s;

    // Scan upward; a later candidate only replaces the current pick when it is
    // strictly older, which gives the lowest-index tie-break for free.
    always_comb begin
        found      = 1'b0;
        index      = {AW{1'b0}};
        best_age_s = {AW{1'b0}};
        for (int i = 0; i < VOICES; i++) begin
            if (mask[i] && (!found || (MODE && (ages[i] > best_age_s)))) begin
                found      = 1'b1;
                index      = AW'(i);
                best_age_s = ages[i];
            end else begin
                best_age_s = best_age_s;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Turns note-on/note-off events into per-voice envelope strobes and tracks the
// lifecycle of each voice (FREE / HELD / RELEASING).
//
// Build option: define VOICE_STEAL_EN to steal the oldest RELEASING (else the
// oldest HELD) voice when a note-on finds no FREE voice. Without it such a
// note-on is dropped and counted in dropped_count.
//
// Ports:
//   clock_50_000_000    in   system clock
//   reset_l             in   asynchronous active-low reset
//   event_valid/ready   in/out  event handshake, one event per two cycles
//   event_is_on         in   1 = note-on, 0 = note-off
//   event_note          in   MIDI note number
//   event_velocity      in   velocity; 0 on a note-on means note-off
//   voice_note_on       out  one-cycle per-voice note_on strobe
//   voice_note_off      out  one-cycle per-voice note_off strobe
//   voice_envelope_end  in   per-voice end-of-release from the envelopes
//   voice_note          out  note held by each voice
//   voice_velocity      out  velocity held by each voice
//   voice_state         out  per-voice voice_state_t (debug)
//   active_count        out  number of non-FREE voices
//   dropped_count       out  saturating count of discarded note-ons
// -----------------------------------------------------------------------------
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICES     = VOICE_COUNT,
    parameter int NOTE_WIDTH = 7
) (
    input  logic                                clock_50_000_000,
    input  logic                                reset_l,
    input  logic                                event_valid,
    output logic                                event_ready,
    input  logic                                event_is_on,
    input  logic [NOTE_WIDTH-1:0]               event_note,
    input  logic [NOTE_WIDTH-1:0]               event_velocity,
    output logic [VOICES-1:0]                   voice_note_on,
    output logic [VOICES-1:0]                   voice_note_off,
    input  logic [VOICES-1:0]                   voice_envelope_end,
    output logic [VOICES-1:0][NOTE_WIDTH-1:0]   voice_note,
    output logic [VOICES-1:0][NOTE_WIDTH-1:0]   voice_velocity,
    output logic [VOICES-1:0][1:0]              voice_state,
    output logic [$clog2(VOICES):0]             active_count,
    output logic [15:0]                         dropped_count
);

    localparam int AW = $clog2(VOICES);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0]     AGE_MAX = AW'(VOICES - 1);
    localparam logic [VOICES-1:0] ONE_HOT0 = {{(VOICES-1){1'b0}}, 1'b1};

    // Registered state
    voice_state_t                           state_q [VOICES];
    voice_state_t                           state_d [VOICES];
    logic [VOICES-1:0][AW-1:0]              age_q, age_d;
    logic [VOICES-1:0][NOTE_WIDTH-1:0]      note_q, note_d;
    logic [VOICES-1:0][NOTE_WIDTH-1:0]      vel_q, vel_d;
    logic [VOICES-1:0]                      note_on_q, note_on_d;
    logic [VOICES-1:0]                      note_off_q, note_off_d;
    logic [CW-1:0]                          active_q, active_d;
    logic [15:0]                            dropped_q, dropped_d;
    logic                                   ready_q, ready_d;

    // Decision signals
    logic                                   accept_s;
    logic                                   note_on_evt_s;
    logic [VOICES-1:0]                      free_mask_s;
    logic [VOICES-1:0]                      match_mask_s;
    logic                                   free_found_s, match_found_s;
    logic [AW-1:0]                          free_idx_s, match_idx_s;
    logic                                   take_found_s;
    logic [AW-1:0]                          take_idx_s;
    logic [VOICES-1:0]                      take_oh_s, match_oh_s;

    assign accept_s      = event_valid && ready_q;
    assign note_on_evt_s = event_is_on && (event_velocity != {NOTE_WIDTH{1'b0}});

    // Candidate masks from the pre-edge state: a voice retiring on this edge
    // is still RELEASING here, so it is never offered as FREE.
    always_comb begin
        free_mask_s  = {VOICES{1'b0}};
        match_mask_s = {VOICES{1'b0}};
        for (int i = 0; i < VOICES; i++) begin
            free_mask_s[i]  = (state_q[i] == FREE);
            match_mask_s[i] = (state_q[i] == HELD) && (note_q[i] == event_note);
        end
    end

    voice_picker #(.VOICES(VOICES), .AW(AW), .MODE(1'b0)) u_free_pick (
        .mask  (free_mask_s),
        .ages  (age_q),
        .found (free_found_s),
        .index (free_idx_s)
    );

    voice_picker #(.VOICES(VOICES), .AW(AW), .MODE(1'b0)) u_match_pick (
        .mask  (match_mask_s),
        .ages  (age_q),
        .found (match_found_s),
        .index (match_idx_s)
    );

`ifdef VOICE_STEAL_EN
    logic [VOICES-1:0] rel_mask_s, held_mask_s;
    logic              rel_found_s, held_found_s;
    logic [AW-1:0]     rel_idx_s, held_idx_s;

    // Steal candidates, split so RELEASING voices are preferred over HELD ones.
    always_comb begin
        rel_mask_s  = {VOICES{1'b0}};
        held_mask_s = {VOICES{1'b0}};
        for (int i = 0; i < VOICES; i++) begin
            rel_mask_s[i]  = (state_q[i] == RELEASING);
            held_mask_s[i] = (state_q[i] == HELD);
        end
    end

    voice_picker #(.VOICES(VOICES), .AW(AW), .MODE(1'b1)) u_steal_rel_pick (
        .mask  (rel_mask_s),
        .ages  (age_q),
        .found (rel_found_s),
        .index (rel_idx_s)
    );

    voice_picker #(.VOICES(VOICES), .AW(AW), .MODE(1'b1)) u_steal_held_pick (
        .mask  (held_mask_s),
        .ages  (age_q),
        .found (held_found_s),
        .index (held_idx_s)
    );
`endif

    // Note-on target priority: retrigger same note, then a free voice, then steal.
    always_comb begin
        take_found_s = 1'b0;
        take_idx_s   = {AW{1'b0}};
        if (match_found_s) begin
            take_found_s = 1'b1;
            take_idx_s   = match_idx_s;
        end else if (free_found_s) begin
            take_found_s = 1'b1;
            take_idx_s   = free_idx_s;
`ifdef VOICE_STEAL_EN
        end else if (rel_found_s) begin
            take_found_s = 1'b1;
            take_idx_s   = rel_idx_s;
        end else if (held_found_s) begin
            take_found_s = 1'b1;
            take_idx_s   = held_idx_s;
`endif
        end else begin
            take_found_s = 1'b0;
            take_idx_s   = {AW{1'b0}};
        end
    end

    assign take_oh_s  = take_found_s  ? (ONE_HOT0 << take_idx_s)  : {VOICES{1'b0}};
    assign match_oh_s = match_found_s ? (ONE_HOT0 << match_idx_s) : {VOICES{1'b0}};

    // Next-state: retire finished envelopes first, then apply the accepted
    // event on top, so an event aimed at a retiring voice leaves it HELD.
    always_comb begin
        state_d    = state_q;
        age_d      = age_q;
        note_d     = note_q;
        vel_d      = vel_q;
        note_on_d  = {VOICES{1'b0}};
        note_off_d = {VOICES{1'b0}};
        dropped_d  = dropped_q;
        ready_d    = !accept_s;

        for (int i = 0; i < VOICES; i++) begin
            if (voice_envelope_end[i] && (state_q[i] == RELEASING)) begin
                state_d[i] = FREE;
                age_d[i]   = {AW{1'b0}};
            end else begin
                state_d[i] = state_d[i];
            end
        end

        if (accept_s && note_on_evt_s) begin
            if (take_found_s) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (take_oh_s[i]) begin
                        state_d[i]   = HELD;
                        age_d[i]     = {AW{1'b0}};
                        note_d[i]    = event_note;
                        vel_d[i]     = event_velocity;
                        note_on_d[i] = 1'b1;
                    end else if ((state_d[i] != FREE) && (age_d[i] != AGE_MAX)) begin
                        age_d[i] = age_d[i] + AW'(1'b1);
                    end else begin
                        age_d[i] = age_d[i];
                    end
                end
            end else begin
                dropped_d = sat_inc16(dropped_q);
            end
        end else if (accept_s) begin
            for (int i = 0; i < VOICES; i++) begin
                if (match_oh_s[i]) begin
                    state_d[i]    = RELEASING;
                    note_off_d[i] = 1'b1;
                end else begin
                    state_d[i] = state_d[i];
                end
            end
        end else begin
            dropped_d = dropped_q;
        end
    end

    // Occupancy of the post-edge state.
    always_comb begin
        active_d = {CW{1'b0}};
        for (int i = 0; i < VOICES; i++) begin
            if (state_d[i] != FREE) begin
                active_d = active_d + CW'(1'b1);
            end else begin
                active_d = active_d;
            end
        end
    end

    // State and output registers; reset cancels any strobe in flight.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < VOICES; i++) begin
                state_q[i] <= FREE;
            end
            age_q      <= {(VOICES*AW){1'b0}};
            note_q     <= {(VOICES*NOTE_WIDTH){1'b0}};
            vel_q      <= {(VOICES*NOTE_WIDTH){1'b0}};
            note_on_q  <= {VOICES{1'b0}};
            note_off_q <= {VOICES{1'b0}};
            active_q   <= {CW{1'b0}};
            dropped_q  <= 16'd0;
            ready_q    <= 1'b0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                state_q[i] <= state_d[i];
            end
            age_q      <= age_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            active_q   <= active_d;
            dropped_q  <= dropped_d;
            ready_q    <= ready_d;
        end
    end

    // Debug view of the per-voice state.
    always_comb begin
        voice_state = {(VOICES*2){1'b0}};
        for (int i = 0; i < VOICES; i++) begin
            voice_state[i] = state_q[i];
        end
    end

    assign event_ready    = ready_q;
    assign voice_note_on  = note_on_q;
    assign voice_note_off = note_off_q;
    assign voice_note     = note_q;
    assign voice_velocity = vel_q;
    assign active_count   = active_q;
    assign dropped_count  = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
// Directed scenarios for a 4-voice allocator plus a randomized run checked
// against a behavioural model (voice ages derived from note-on timestamps).
// Honours VOICE_STEAL_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

    localparam int V  = 4;
    localparam int NW = 7;

    logic                 clk = 1'b0;
    logic                 reset_l;
    logic                 event_valid;
    logic                 event_ready;
    logic                 event_is_on;
    logic [NW-1:0]        event_note;
    logic [NW-1:0]        event_velocity;
    logic [V-1:0]         voice_note_on;
    logic [V-1:0]         voice_note_off;
    logic [V-1:0]         voice_envelope_end;
    logic [V-1:0][NW-1:0] voice_note;
    logic [V-1:0][NW-1:0] voice_velocity;
    logic [V-1:0][1:0]    voice_state;
    logic [2:0]           active_count;
    logic [15:0]          dropped_count;

    int vectors     = 0;
    int miscompares = 0;

    // Model: 0 free, 1 held, 2 releasing
    int           m_state [V];
    int           m_note  [V];
    int           m_vel   [V];
    int           m_stamp [V];
    int           m_ons;
    int           m_dropped;
    logic         m_ready;
    logic [V-1:0] exp_on;
    logic [V-1:0] exp_off;

    voice_allocator #(.VOICES(V), .NOTE_WIDTH(NW)) dut (
        .clock_50_000_000   (clk),
        .reset_l            (reset_l),
        .event_valid        (event_valid),
        .event_ready        (event_ready),
        .event_is_on        (event_is_on),
        .event_note         (event_note),
        .event_velocity     (event_velocity),
        .voice_note_on      (voice_note_on),
        .voice_note_off     (voice_note_off),
        .voice_envelope_end (voice_envelope_end),
        .voice_note         (voice_note),
        .voice_velocity     (voice_velocity),
        .voice_state        (voice_state),
        .active_count       (active_count),
        .dropped_count      (dropped_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_state[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = 0;
        end
        m_ons = 0; m_dropped = 0; m_ready = 1'b0;
        exp_on = '0; exp_off = '0;
    endtask

    // Age = note-ons granted since this voice was taken, capped at V-1.
    function automatic int model_age(input int i);
        int a;
        a = m_ons - m_stamp[i];
        return (a > V - 1) ? V - 1 : a;
    endfunction

    function automatic int model_active();
        int n = 0;
        for (int i = 0; i < V; i++) if (m_state[i] != 0) n++;
        return n;
    endfunction

    function automatic int oldest(input int st, input int pst [V]);
        int pick = -1;
        for (int i = 0; i < V; i++)
            if (pst[i] == st && (pick < 0 || model_age(i) > model_age(pick))) pick = i;
        return pick;
    endfunction

    task automatic model_edge(input logic valid, input logic is_on, input int note,
                              input int vel, input logic [V-1:0] env);
        int   pst [V];
        int   pick;
        logic acc;
        exp_on  = '0;
        exp_off = '0;
        acc     = valid && m_ready;
        m_ready = !acc;
        for (int i = 0; i < V; i++) pst[i] = m_state[i];
        for (int i = 0; i < V; i++) if (env[i] && pst[i] == 2) m_state[i] = 0;
        pick = -1;
        if (acc && is_on && vel != 0) begin
            for (int i = 0; i < V; i++) if (pick < 0 && pst[i] == 1 && m_note[i] == note) pick = i;
            for (int i = 0; i < V; i++) if (pick < 0 && pst[i] == 0) pick = i;
`ifdef VOICE_STEAL_EN
            if (pick < 0) pick = oldest(2, pst);
            if (pick < 0) pick = oldest(1, pst);
`endif
            if (pick >= 0) begin
                m_ons++;
                m_stamp[pick] = m_ons;
                m_state[pick] = 1;
                m_note[pick]  = note;
                m_vel[pick]   = vel;
                exp_on[pick]  = 1'b1;
            end else if (m_dropped < 65535) begin
                m_dropped++;
            end
        end else if (acc) begin
            for (int i = 0; i < V; i++) if (pick < 0 && pst[i] == 1 && m_note[i] == note) pick = i;
            if (pick >= 0) begin
                m_state[pick] = 2;
                exp_off[pick] = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, step the edge, leave time at edge+1.
    task automatic cyc(input logic valid, input logic is_on, input int note,
                       input int vel, input logic [V-1:0] env);
        event_valid        = valid;
        event_is_on        = is_on;
        event_note         = NW'(note);
        event_velocity     = NW'(vel);
        voice_envelope_end = env;
        @(posedge clk);
        #1;
        model_edge(valid, is_on, note, vel, env);
        event_valid        = 1'b0;
        voice_envelope_end = '0;
    endtask

    task automatic send(input logic is_on, input int note, input int vel, input logic [V-1:0] env);
        cyc(1'b1, is_on, note, vel, env);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 0, 4'b0000);
    endtask

    task automatic apply_reset();
        reset_l = 1'b0;
        event_valid = 1'b0;
        voice_envelope_end = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        model_reset();
        idle();
    endtask

    task automatic fill4();
        send(1'b1, 60, 100, 4'b0000); idle();
        send(1'b1, 62, 100, 4'b0000); idle();
        send(1'b1, 64, 100, 4'b0000); idle();
        send(1'b1, 65, 100, 4'b0000); idle();
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        event_valid = 1'b0; event_is_on = 1'b0; event_note = '0; event_velocity = '0;
        voice_envelope_end = '0;
        @(posedge clk);
        #1;
        vectors++;
        if (event_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready: got %b want 0", event_ready);
        end
        vectors++;
        if (voice_note_on !== 4'b0000 || voice_note_off !== 4'b0000) begin
            miscompares++; $display("FAIL reset_strobes: got %b/%b want 0000/0000", voice_note_on, voice_note_off);
        end
        vectors++;
        if (active_count !== 3'd0 || dropped_count !== 16'd0 || voice_state !== 8'h00
            || voice_note !== 28'h0 || voice_velocity !== 28'h0) begin
            miscompares++; $display("FAIL reset_state: active %0d dropped %0d state %h want all 0",
                                    active_count, dropped_count, voice_state);
        end
        reset_l = 1'b1;
        model_reset();
        vectors++;
        if (event_ready !== 1'b0) begin
            miscompares++; $display("FAIL ready_before_edge: got %b want 0", event_ready);
        end
        idle();
        vectors++;
        if (event_ready !== 1'b1) begin
            miscompares++; $display("FAIL ready_after_edge: got %b want 1", event_ready);
        end
    endtask

    task automatic test_basic_on();
        apply_reset();
        send(1'b1, 60, 100, 4'b0000);
        vectors++;
        if (voice_note_on !== 4'b0001 || voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd100) begin
            miscompares++; $display("FAIL basic_on: on %b note %0d vel %0d want 0001 60 100",
                                    voice_note_on, voice_note[0], voice_velocity[0]);
        end
        vectors++;
        if (active_count !== 3'd1 || event_ready !== 1'b0) begin
            miscompares++; $display("FAIL basic_t1: active %0d ready %b want 1 0", active_count, event_ready);
        end
        idle();
        vectors++;
        if (event_ready !== 1'b1 || voice_note_on !== 4'b0000) begin
            miscompares++; $display("FAIL basic_t2: ready %b on %b want 1 0000", event_ready, voice_note_on);
        end
    endtask

    task automatic test_release();
        apply_reset();
        send(1'b1, 60, 100, 4'b0000); idle();
        send(1'b1, 62, 100, 4'b0000); idle();
        send(1'b1, 64, 100, 4'b0000); idle();
        send(1'b0, 62, 0, 4'b0000);
        vectors++;
        if (voice_note_off !== 4'b0010 || voice_note_on !== 4'b0000 || voice_state[1] !== 2'd2) begin
            miscompares++; $display("FAIL note_off: off %b on %b state1 %0d want 0010 0000 2",
                                    voice_note_off, voice_note_on, voice_state[1]);
        end
        idle();
        cyc(1'b0, 1'b0, 0, 0, 4'b0011);
        vectors++;
        if (voice_state[1] !== 2'd0 || voice_state[0] !== 2'd1 || active_count !== 3'd2) begin
            miscompares++; $display("FAIL env_end: state1 %0d state0 %0d active %0d want 0 1 2",
                                    voice_state[1], voice_state[0], active_count);
        end
        send(1'b1, 67, 90, 4'b0000);
        vectors++;
        if (voice_note_on !== 4'b0010 || voice_note[1] !== 7'd67) begin
            miscompares++; $display("FAIL reuse_free: on %b note1 %0d want 0010 67", voice_note_on, voice_note[1]);
        end
        idle();
    endtask

    task automatic test_retrigger();
        apply_reset();
        send(1'b1, 60, 100, 4'b0000); idle();
        send(1'b1, 60, 90, 4'b0000);
        vectors++;
        if (voice_note_on !== 4'b0001 || active_count !== 3'd1 || voice_velocity[0] !== 7'd90) begin
            miscompares++; $display("FAIL retrigger: on %b active %0d vel0 %0d want 0001 1 90",
                                    voice_note_on, active_count, voice_velocity[0]);
        end
        idle();
        send(1'b1, 60, 0, 4'b0000);
        vectors++;
        if (voice_note_off !== 4'b0001 || voice_note_on !== 4'b0000 || voice_state[0] !== 2'd2) begin
            miscompares++; $display("FAIL vel0_off: off %b on %b state0 %0d want 0001 0000 2",
                                    voice_note_off, voice_note_on, voice_state[0]);
        end
        idle();
    endtask

    task automatic test_full();
        apply_reset();
        fill4();
        send(1'b1, 67, 100, 4'b0000);
`ifdef VOICE_STEAL_EN
        vectors++;
        if (voice_note_on !== 4'b0001 || voice_note_off !== 4'b0000 || voice_note[0] !== 7'd67
            || dropped_count !== 16'd0) begin
            miscompares++; $display("FAIL steal_held: on %b off %b note0 %0d dropped %0d want 0001 0000 67 0",
                                    voice_note_on, voice_note_off, voice_note[0], dropped_count);
        end
`else
        vectors++;
        if (voice_note_on !== 4'b0000 || dropped_count !== 16'd1 || voice_note[0] !== 7'd60) begin
            miscompares++; $display("FAIL drop: on %b dropped %0d note0 %0d want 0000 1 60",
                                    voice_note_on, dropped_count, voice_note[0]);
        end
`endif
        vectors++;
        if (active_count !== 3'd4) begin
            miscompares++; $display("FAIL full_active: got %0d want 4", active_count);
        end
        idle();
    endtask

    task automatic test_steal_releasing();
        apply_reset();
        fill4();
        send(1'b0, 64, 0, 4'b0000);
        vectors++;
        if (voice_note_off !== 4'b0100) begin
            miscompares++; $display("FAIL off64: got %b want 0100", voice_note_off);
        end
        idle();
        send(1'b1, 69, 80, 4'b0000);
`ifdef VOICE_STEAL_EN
        vectors++;
        if (voice_note_on !== 4'b0100 || voice_note[2] !== 7'd69 || voice_state[2] !== 2'd1) begin
            miscompares++; $display("FAIL steal_rel: on %b note2 %0d state2 %0d want 0100 69 1",
                                    voice_note_on, voice_note[2], voice_state[2]);
        end
`else
        vectors++;
        if (voice_note_on !== 4'b0000 || dropped_count !== 16'd1 || voice_state[2] !== 2'd2) begin
            miscompares++; $display("FAIL drop_rel: on %b dropped %0d state2 %0d want 0000 1 2",
                                    voice_note_on, dropped_count, voice_state[2]);
        end
`endif
        idle();
        // Same again, with the envelope of voice 2 ending on the accept edge.
        apply_reset();
        fill4();
        send(1'b0, 64, 0, 4'b0000); idle();
        send(1'b1, 69, 80, 4'b0100);
`ifdef VOICE_STEAL_EN
        vectors++;
        if (voice_note_on !== 4'b0100 || voice_note[2] !== 7'd69 || voice_state[2] !== 2'd1
            || active_count !== 3'd4) begin
            miscompares++; $display("FAIL steal_vs_end: on %b note2 %0d state2 %0d active %0d want 0100 69 1 4",
                                    voice_note_on, voice_note[2], voice_state[2], active_count);
        end
`else
        vectors++;
        if (voice_note_on !== 4'b0000 || dropped_count !== 16'd1 || voice_state[2] !== 2'd0
            || active_count !== 3'd3) begin
            miscompares++; $display("FAIL drop_vs_end: on %b dropped %0d state2 %0d active %0d want 0000 1 0 3",
                                    voice_note_on, dropped_count, voice_state[2], active_count);
        end
`endif
        idle();
    endtask

    task automatic test_nomatch_and_midreset();
        apply_reset();
        send(1'b1, 60, 100, 4'b0000); idle();
        send(1'b0, 70, 0, 4'b0000);
        vectors++;
        if (voice_note_on !== 4'b0000 || voice_note_off !== 4'b0000 || active_count !== 3'd1
            || voice_state[0] !== 2'd1) begin
            miscompares++; $display("FAIL nomatch_off: on %b off %b active %0d state0 %0d want 0000 0000 1 1",
                                    voice_note_on, voice_note_off, active_count, voice_state[0]);
        end
        idle();
        send(1'b1, 62, 100, 4'b0000);
        vectors++;
        if (voice_note_on !== 4'b0010) begin
            miscompares++; $display("FAIL pre_reset_strobe: got %b want 0010", voice_note_on);
        end
        reset_l = 1'b0;
        #1;
        vectors++;
        if (voice_note_on !== 4'b0000 || voice_state !== 8'h00 || active_count !== 3'd0 || event_ready !== 1'b0) begin
            miscompares++; $display("FAIL async_reset: on %b state %h active %0d ready %b want 0000 00 0 0",
                                    voice_note_on, voice_state, active_count, event_ready);
        end
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        model_reset();
        idle();
    endtask

    task automatic test_random();
        logic         v, on;
        int           note, vel;
        logic [V-1:0] env;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            on   = ($urandom_range(0, 2) != 0);
            note = 60 + $urandom_range(0, 5);
            vel  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            for (int i = 0; i < V; i++) env[i] = ($urandom_range(0, 3) == 0);
            cyc(v, on, note, vel, env);
            vectors++;
            if (event_ready !== m_ready) begin
                miscompares++; $display("FAIL rnd_ready @%0d: got %b want %b", n, event_ready, m_ready);
            end
            vectors++;
            if (voice_note_on !== exp_on || voice_note_off !== exp_off) begin
                miscompares++; $display("FAIL rnd_strobe @%0d: on %b off %b want %b %b",
                                        n, voice_note_on, voice_note_off, exp_on, exp_off);
            end
            for (int i = 0; i < V; i++) begin
                vectors++;
                if (voice_state[i] !== 2'(m_state[i]) || voice_note[i] !== NW'(m_note[i])
                    || voice_velocity[i] !== NW'(m_vel[i])) begin
                    miscompares++; $display("FAIL rnd_voice%0d @%0d: st %0d note %0d vel %0d want %0d %0d %0d",
                                            i, n, voice_state[i], voice_note[i], voice_velocity[i],
                                            m_state[i], m_note[i], m_vel[i]);
                end
            end
            vectors++;
            if (active_count !== 3'(model_active()) || dropped_count !== 16'(m_dropped)) begin
                miscompares++; $display("FAIL rnd_counts @%0d: active %0d dropped %0d want %0d %0d",
                                        n, active_count, dropped_count, model_active(), m_dropped);
            end
        end
    endtask

    initial begin
        reset_l = 1'b0;
        event_valid = 1'b0;
        event_is_on = 1'b0;
        event_note = '0;
        event_velocity = '0;
        voice_envelope_end = '0;
        model_reset();
        test_reset();
        test_basic_on();
        test_release();
        test_retrigger();
        test_full();
        test_steal_releasing();
        test_nomatch_and_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator sitting between the MIDI event decoder and the bank of per-voice `Envelope` instances. It turns a stream of note-on/note-off events into per-voice `note_on`/`note_off` strobes, tracks each voice's lifecycle, and frees a voice when its envelope reports `envelope_end`. It is the driving end of the envelope's note interface: every strobe it emits is consumed by exactly one envelope, and every `envelope_end` it receives retires exactly one voice.

## Interface
- `VOICES`, default `CONFIG::VOICE_COUNT` (8): number of voices/envelopes driven; power of two, 2..16.
- `NOTE_WIDTH`, default 7: MIDI note/velocity width.

- `clock_50_000_000`  in  1  system clock.
- `reset_l`  in  1  asynchronous, active-low reset.
- `event_valid`  in  1  note event present.
- `event_ready`  out  1  allocator can accept; an event transfers when `event_valid && event_ready`.
- `event_is_on`  in  1  1 = note-on, 0 = note-off.
- `event_note`  in  `NOTE_WIDTH`  MIDI note number.
- `event_velocity`  in  `NOTE_WIDTH`  velocity; note-on with velocity 0 is treated as note-off.
- `voice_note_on`  out  `VOICES`  one-cycle strobe per voice, to `Envelope.note_on`.
- `voice_note_off`  out  `VOICES`  one-cycle strobe per voice, to `Envelope.note_off`.
- `voice_envelope_end`  in  `VOICES`  per-voice `envelope_end` from the envelopes.
- `voice_note`  out  `VOICES`×`NOTE_WIDTH`  note assigned to each voice (to the oscillators).
- `voice_velocity`  out  `VOICES`×`NOTE_WIDTH`  velocity assigned to each voice.
- `voice_state`  out  `VOICES`×2  per-voice `VOICE::voice_state_t` (debug).
- `active_count`  out  `$clog2(VOICES)+1`  number of non-FREE voices.
- `dropped_count`  out  16  note-ons discarded for lack of a voice; saturates at 0xFFFF.

## Operation
- Per-voice state: FREE, HELD, RELEASING. Per-voice age: `$clog2(VOICES)` bits.
- Note-on for note N:
  - If a HELD voice already holds N, retrigger the lowest-index such voice: pulse `voice_note_on`, update velocity, reset its age to 0.
  - Otherwise take the lowest-index FREE voice.
  - Otherwise steal (see Configuration).
  - The chosen voice becomes HELD with age 0. Every other non-FREE voice increments its age, saturating at `VOICES-1`.
- Note-off for note N: the lowest-index HELD voice holding N becomes RELEASING and gets a `voice_note_off` pulse. No match means the event is consumed with no effect. RELEASING voices are never matched.
- `voice_envelope_end[i]` with voice i RELEASING: voice i becomes FREE and its age goes to 0. With voice i FREE or HELD it is ignored.
- Ordering on the same edge: `envelope_end` retirement is applied first, then the event decision.
  - The event decision uses the pre-edge state, so a voice retiring this cycle is not seen as FREE.
  - If the event steals or retriggers a voice that is retiring on the same edge, the event wins and the voice ends HELD.
- `voice_note`/`voice_velocity` hold their values when a voice goes FREE.
- `active_count` is registered and reflects the post-edge state.

## Timing
- Reset values: all voices FREE, ages 0, `voice_note_on`/`voice_note_off`=0, `voice_note`/`voice_velocity`=0, `active_count`=0, `dropped_count`=0, `event_ready`=0 while `reset_l` is low and 1 from the first edge after release.
- Event accepted in cycle T:
  - Strobes, `voice_note`, `voice_velocity` and state update are registered and visible in T+1.
  - The strobe is exactly one cycle wide.
  - `voice_note` is valid in the same cycle as `voice_note_on`.
- `event_ready` is 0 in T+1 and 1 again in T+2. Sustained throughput is one event per 2 cycles. `event_ready` does not depend combinationally on `event_valid`.
- At most one bit of `voice_note_on | voice_note_off` is set in any cycle.
- Reset asserted mid-operation: all state clears immediately, and any strobe in flight is cancelled (outputs 0 asynchronously).

## Configuration
- `VOICE_STEAL_EN` defined: on note-on with no FREE voice, steal the oldest RELEASING voice (max age, ties to lowest index). If none are RELEASING, steal the oldest HELD voice. The stolen voice gets only `voice_note_on`, with no preceding `note_off`, since the envelope restarts attack on `note_on`.
- Not defined: such a note-on is dropped, no strobe is emitted, and `dropped_count` increments. `dropped_count` exists in both builds and stays 0 when stealing is enabled.

## Structure
- Package `VOICE`: `voice_state_t` enum {FREE, HELD, RELEASING}, `note_event_t` struct {is_on, note, velocity}, `VOICE_AGE_WIDTH`.
- `CONFIG` gains `VOICE_COUNT`.
- Sub-module `voice_picker`: combinational, parameterized by `VOICES`. Takes per-voice candidate mask and ages; returns `found` plus the index of the lowest-index set bit (mode 0) or the max-age entry with lowest-index tie-break (mode 1). Instantiated for free-search, note-match and steal-search.

## Test plan
All scenarios use `VOICES`=4.
- Reset, then note-on 60 vel 100 → T+1: `voice_note_on`=0001, `voice_note[0]`=60, `active_count`=1; `event_ready` low T+1, high T+2.
- Note-on 60,62,64, then note-off 62 → voice 1 RELEASING, `voice_note_off`=0010. Then pulse `voice_envelope_end[1]` → voice 1 FREE, `active_count`=2. A following note-on 67 lands on voice 1.
- Note-on 60 twice → second event retriggers voice 0 (`voice_note_on`=0001), `active_count` stays 1. Note-on 60 vel 0 → `voice_note_off`=0001.
- Fill voices with 60,62,64,65, then note-on 67:
  - With `VOICE_STEAL_EN`: voice 0 stolen, `voice_note[0]`=67, no note_off strobe.
  - Without it: no strobe, `dropped_count`=1.
- All 4 HELD, note-off 64 (voice 2 RELEASING), then note-on 69 with `VOICE_STEAL_EN` → voice 2 stolen. Repeat with `voice_envelope_end[2]` on the accept edge → voice 2 ends HELD with note 69.
- Note-off 70 with no match → no strobe, state unchanged. Assert `reset_l` low in the cycle a strobe is visible → strobe drops to 0 at once, all voices FREE.
